leaf_merge_2way: RTL and testbench

- Leaf merge stage directly downstream of the input module that serialises sorting-network blocks.
- Accepts the 32-bit element stream from that module. Steers consecutive sorted runs of RUN elements alternately into two lane FIFOs (A, B).
- Merges each A/B run pair into one sorted run of 2*RUN elements, which feeds the next merge sorter tree level.
- Drives `full` back to the input module; honours `out_full` from the next level.

---
 rtl/leaf_merge_2way.sv | 164 ++++++++++++++++
 tb/tb_leaf_merge_2way.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_merge_2way.sv
// Leaf merge stage: steers incoming sorted runs of RUN elements alternately into two
// FWFT lanes and merges each lane pair into one 2*RUN run. Define LEAF_MERGE_DESCEND_EN for descending runs.
module leaf_merge_2way #(
   parameter int unsigned W     = 32,
   parameter int unsigned RUN   = 16,
   parameter int unsigned DEPTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         enq,
   output logic         full,
   output logic [W-1:0] dout,
   output logic         out_enq,
   output logic         out_last,
   input  logic         out_full
);

   localparam int unsigned RUN_W = $clog2(RUN);
   localparam int unsigned REM_W = $clog2(RUN) + 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, MERGE, DRAIN_A, DRAIN_B} state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     mem_a [DEPTH];
   logic [W-1:0]     mem_b [DEPTH];
   logic [PTR_W-1:0] wp_a, rp_a, wp_b, rp_b;
   logic [CNT_W-1:0] cnt_a, cnt_b;
   logic [RUN_W-1:0] in_cnt;
   logic             in_sel;
   logic [REM_W-1:0] rem_a, rem_b, rem_a_nxt, rem_b_nxt;
   logic             acc, wr_a, wr_b, pop_a, pop_b;
   logic             has_a, has_b, a_wins;
   logic [W-1:0]     head_a, head_b;

   // Input acceptance against the currently selected lane
   assign full   = in_sel ? (cnt_b == CNT_W'(DEPTH)) : (cnt_a == CNT_W'(DEPTH));
   assign acc    = enq & ~full;
   assign wr_a   = acc & ~in_sel;
   assign wr_b   = acc & in_sel;

   assign has_a  = (cnt_a != '0);
   assign has_b  = (cnt_b != '0);
   assign head_a = mem_a[rp_a];
   assign head_b = mem_b[rp_b];

`ifdef LEAF_MERGE_DESCEND_EN
   assign a_wins = (head_a >= head_b);
`else
   assign a_wins = (head_a <= head_b);
`endif

   // Run steering: toggle lane after every RUN accepted elements
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_cnt <= '0;
         in_sel <= 1'b0;
      end else if (acc) begin
         in_cnt <= in_cnt + RUN_W'(1);
         if (in_cnt == RUN_W'(RUN - 1)) in_sel <= ~in_sel;
      end
   end

   // Lane storage; contents need no reset since pointers and counts are cleared
   always_ff @(posedge clk) begin
      if (wr_a) mem_a[wp_a] <= din;
      if (wr_b) mem_b[wp_b] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_a  <= '0;
         rp_a  <= '0;
         cnt_a <= '0;
         wp_b  <= '0;
         rp_b  <= '0;
         cnt_b <= '0;
      end else begin
         if (wr_a)  wp_a <= wp_a + PTR_W'(1);
         if (pop_a) rp_a <= rp_a + PTR_W'(1);
         if (wr_b)  wp_b <= wp_b + PTR_W'(1);
         if (pop_b) rp_b <= rp_b + PTR_W'(1);
         cnt_a <= cnt_a + CNT_W'(wr_a) - CNT_W'(pop_a);
         cnt_b <= cnt_b + CNT_W'(wr_b) - CNT_W'(pop_b);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         rem_a <= '0;
         rem_b <= '0;
      end else begin
         state <= state_nxt;
         rem_a <= rem_a_nxt;
         rem_b <= rem_b_nxt;
      end
   end

   // Merge control; rem counters keep later queued runs out of the current merge
   always_comb begin
      state_nxt = state;
      rem_a_nxt = rem_a;
      rem_b_nxt = rem_b;
      pop_a     = 1'b0;
      pop_b     = 1'b0;
      out_enq   = 1'b0;
      out_last  = 1'b0;
      dout      = '0;
      case (state)
         IDLE: begin
            if (has_a && has_b) begin
               rem_a_nxt = REM_W'(RUN);
               rem_b_nxt = REM_W'(RUN);
               state_nxt = MERGE;
            end
         end
         MERGE: begin
            if (has_a && has_b && !out_full) begin
               out_enq = 1'b1;
               if (a_wins) begin
                  pop_a     = 1'b1;
                  dout      = head_a;
                  rem_a_nxt = rem_a - REM_W'(1);
                  if (rem_a == REM_W'(1)) state_nxt = DRAIN_B;
               end else begin
                  pop_b     = 1'b1;
                  dout      = head_b;
                  rem_b_nxt = rem_b - REM_W'(1);
                  if (rem_b == REM_W'(1)) state_nxt = DRAIN_A;
               end
            end
         end
         DRAIN_A: begin
            if (has_a && !out_full) begin
               out_enq   = 1'b1;
               pop_a     = 1'b1;
               dout      = head_a;
               rem_a_nxt = rem_a - REM_W'(1);
               if (rem_a == REM_W'(1)) begin
                  out_last  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         DRAIN_B: begin
            if (has_b && !out_full) begin
               out_enq   = 1'b1;
               pop_b     = 1'b1;
               dout      = head_b;
               rem_b_nxt = rem_b - REM_W'(1);
               if (rem_b == REM_W'(1)) begin
                  out_last  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_leaf_merge_2way.sv
// Bench for leaf_merge_2way: directed run-pair table, reset/fill sequences and
// randomized traffic against a sort-based reference model.
module tb_leaf_merge_2way;

   localparam int unsigned W     = 32;
   localparam int unsigned RUN   = 16;
   localparam int unsigned DEPTH = 32;
   localparam int          LIMIT = 4000;

   logic         clk = 1'b0;
   logic         rst, enq, full, out_enq, out_last, out_full;
   logic [W-1:0] din, dout;

   always #5 clk = ~clk;

   leaf_merge_2way #(.W(W), .RUN(RUN), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .enq      (enq),
      .full     (full),
      .dout     (dout),
      .out_enq  (out_enq),
      .out_last (out_last),
      .out_full (out_full)
   );

   typedef struct packed {
      logic [2*RUN-1:0][W-1:0] e;
      logic [RUN-1:0][W-1:0]   b;
      logic [RUN-1:0][W-1:0]   a;
      logic [7:0]              bp_lo;
      logic [7:0]              bp_hi;
      logic [7:0]              span;
   } vec_t;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      int           cyc;
   } rx_t;

   vec_t         vecs [4];
   rx_t          rx_q [$];
   logic [W-1:0] tx_q [$];
   logic [W-1:0] exp_q [$];
   int           checks = 0;
   int           passed = 0;
   int           cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
   endtask

   // Output monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         if (!out_enq) begin
            chk("dout_zero_when_idle", dout, '0);
            chk("last_only_with_enq", W'(out_last), '0);
         end
         if (out_full) chk("out_enq_under_out_full", W'(out_enq), '0);
         if (out_enq) rx_q.push_back('{dout, out_last, cyc});
      end
   end

   function automatic logic [W-1:0] rval();
      if ($urandom_range(3) == 0) return W'($urandom);
      return W'($urandom_range(40));
   endfunction

   function automatic logic [W-1:0] fill_val(input int k);
`ifdef LEAF_MERGE_DESCEND_EN
      return W'((k / 16) * 16 + 15 - (k % 16));
`else
      return W'(k);
`endif
   endfunction

   // Reference: a merged pair is simply the sorted union of both runs
   task automatic push_pair(input logic [W-1:0] ra[$], input logic [W-1:0] rb[$], input bit to_tx);
      logic [W-1:0] m [$];
      m = {ra, rb};
`ifdef LEAF_MERGE_DESCEND_EN
      m.rsort();
`else
      m.sort();
`endif
      foreach (m[j]) exp_q.push_back(m[j]);
      if (to_tx) begin
         foreach (ra[j]) tx_q.push_back(ra[j]);
         foreach (rb[j]) tx_q.push_back(rb[j]);
      end
   endtask

   task automatic gen_random(input int npairs);
      logic [W-1:0] ra [$];
      logic [W-1:0] rb [$];
      for (int p = 0; p < npairs; p++) begin
         ra.delete();
         rb.delete();
         for (int i = 0; i < RUN; i++) begin
            ra.push_back(rval());
            rb.push_back(rval());
         end
`ifdef LEAF_MERGE_DESCEND_EN
         ra.rsort();
         rb.rsort();
`else
         ra.sort();
         rb.sort();
`endif
         push_pair(ra, rb, 1'b1);
      end
   endtask

   // Drives tx_q and out_full from posedge+1; out_full window counts cycles from first output
   task automatic run_traffic(input int enq_pct, input int bp_pct, input int bp_lo, input int bp_hi,
                              input int n_out);
      int   budget = 0;
      int   first = -1;
      int   k;
      logic acc;
      while ((tx_q.size() > 0 || rx_q.size() < n_out) && budget < LIMIT) begin
         enq = (tx_q.size() > 0) && ($urandom_range(99) < enq_pct);
         din = enq ? tx_q[0] : '0;
         if (rx_q.size() > 0 && first < 0) first = rx_q[0].cyc;
         k = (first < 0) ? -1 : cyc - first;
         out_full = (k >= bp_lo && k <= bp_hi) || ($urandom_range(99) < bp_pct);
         @(negedge clk);
         acc = enq && !full;
         @(posedge clk);
         #1;
         if (acc) void'(tx_q.pop_front());
         budget++;
      end
      enq      = 1'b0;
      din      = '0;
      out_full = 1'b0;
      chk("traffic_timeout", W'(budget >= LIMIT), '0);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic compare(input string name, input int span);
      chk({name, "_count"}, W'(rx_q.size()), W'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++) begin
         chk($sformatf("%s_data[%0d]", name, j), rx_q[j].data, exp_q[j]);
         chk($sformatf("%s_last[%0d]", name, j), W'(rx_q[j].last), W'((j % (2 * RUN)) == 2 * RUN - 1));
      end
      if (span >= 0 && rx_q.size() > 0)
         chk({name, "_span"}, W'(rx_q[rx_q.size()-1].cyc - rx_q[0].cyc), W'(span));
   endtask

   task automatic build_vecs();
      for (int v = 0; v < 4; v++) begin
         vecs[v].bp_lo = 8'd1;
         vecs[v].bp_hi = 8'd0;
         vecs[v].span  = 8'd31;
      end
      vecs[1].bp_lo = 8'd5;
      vecs[1].bp_hi = 8'd14;
      vecs[1].span  = 8'd41;
      for (int i = 0; i < RUN; i++) begin
`ifdef LEAF_MERGE_DESCEND_EN
         vecs[0].a[i] = W'(31 - 2 * i);  vecs[0].b[i] = W'(30 - 2 * i);
         vecs[2].a[i] = W'(115 - i);     vecs[2].b[i] = W'(15 - i);
         vecs[3].a[i] = W'(15 - i);      vecs[3].b[i] = W'(15 - i);
`else
         vecs[0].a[i] = W'(2 * i);       vecs[0].b[i] = W'(2 * i + 1);
         vecs[2].a[i] = W'(100 + i);     vecs[2].b[i] = W'(i);
         vecs[3].a[i] = W'(i);           vecs[3].b[i] = W'(i);
`endif
      end
      for (int j = 0; j < 2 * RUN; j++) begin
`ifdef LEAF_MERGE_DESCEND_EN
         vecs[0].e[j] = W'(31 - j);
         vecs[2].e[j] = (j < 16) ? W'(115 - j) : W'(31 - j);
         vecs[3].e[j] = W'(15 - j / 2);
`else
         vecs[0].e[j] = W'(j);
         vecs[2].e[j] = (j < 16) ? W'(j) : W'(84 + j);
         vecs[3].e[j] = W'(j / 2);
`endif
      end
      vecs[1].a = vecs[0].a;
      vecs[1].b = vecs[0].b;
      vecs[1].e = vecs[0].e;
   endtask

   task automatic load_vec(input int v);
      exp_q.delete();
      for (int i = 0; i < RUN; i++) tx_q.push_back(vecs[v].a[i]);
      for (int i = 0; i < RUN; i++) tx_q.push_back(vecs[v].b[i]);
      for (int j = 0; j < 2 * RUN; j++) exp_q.push_back(vecs[v].e[j]);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_full"}, W'(full), '0);
      chk({name, "_out_enq"}, W'(out_enq), '0);
      chk({name, "_out_last"}, W'(out_last), '0);
      chk({name, "_dout"}, dout, '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra [$];
      logic [W-1:0] rb [$];
      int           budget;

      rst = 1'b0; enq = 1'b0; din = '0; out_full = 1'b0;
      build_vecs();
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      // Reset in the middle of traffic discards partial runs and queued data
      out_full = 1'b1;
      for (int i = 0; i < 53; i++) begin
         enq = 1'b1;
         din = W'(i * 3 + 7);
         @(posedge clk); #1;
      end
      enq = 1'b0;
      rx_q.delete();
      rst = 1'b0;
      out_full = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      @(posedge clk); #1;
      rst = 1'b1;
      load_vec(0);
      run_traffic(100, 0, 1, 0, 2 * RUN);
      compare("post_reset", 31);

      // Directed run pairs
      for (int v = 0; v < 4; v++) begin
         rx_q.delete();
         load_vec(v);
         run_traffic(100, 0, int'(vecs[v].bp_lo), int'(vecs[v].bp_hi), 2 * RUN);
         compare($sformatf("vec%0d", v), int'(vecs[v].span));
      end

      // Randomized traffic and backpressure
      for (int r = 0; r < 3; r++) begin
         rx_q.delete();
         exp_q.delete();
         gen_random(4);
         run_traffic((r == 0) ? 100 : (r == 1) ? 60 : 90, (r == 0) ? 0 : (r == 1) ? 40 : 70,
                     1, 0, 8 * RUN);
         compare($sformatf("rand%0d", r), -1);
      end

      // Fill both lanes under backpressure; surplus pulses must be dropped
      rx_q.delete();
      exp_q.delete();
      for (int p = 0; p < 2; p++) begin
         ra.delete();
         rb.delete();
         for (int i = 0; i < RUN; i++) begin
            ra.push_back(fill_val(p * 32 + i));
            rb.push_back(fill_val(p * 32 + 16 + i));
         end
         push_pair(ra, rb, 1'b0);
      end
      out_full = 1'b1;
      for (int p = 1; p <= 70; p++) begin
         enq = 1'b1;
         din = fill_val(p - 1);
         @(negedge clk);
         chk($sformatf("fill_full[%0d]", p), W'(full), W'(p > 64));
         @(posedge clk); #1;
      end
      enq = 1'b0;
      din = '0;
      @(negedge clk);
      chk("fill_full_hold", W'(full), W'(1));
      @(posedge clk); #1;
      out_full = 1'b0;
      budget = 0;
      while (rx_q.size() < 4 * RUN && budget < LIMIT) begin
         @(posedge clk); #1;
         budget++;
      end
      chk("fill_timeout", W'(budget >= LIMIT), '0);
      repeat (5) @(posedge clk);
      #1;
      compare("fill", 64);
      @(negedge clk);
      chk("fill_full_release", W'(full), '0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
